// File: rtl/dispatch_sequencer_pkg.sv
// Shared types and opcode match constants for the fetch-to-dispatch instruction queue.
// The mask/match pairs are the single source for the pre-decode classifier.
package dispatch_sequencer_pkg;

  localparam int INSNBITS_SIZE = 32;

  typedef enum logic {
    SEQ_RUN    = 1'b0,
    SEQ_HALTED = 1'b1
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LS  = 2'd1,
    CLS_HLT = 2'd2
  } insn_class_t;

  // Primary opcode field, insn[31:21].
  typedef enum logic [10:0] {
    OP_ADDI = 11'h488,
    OP_HLT  = 11'h6A2,
    OP_STUR = 11'h7C0,
    OP_LDUR = 11'h7C2
  } opcode_t;

  // LDUR/STUR: size bit 30 is don't-care so 32- and 64-bit forms both match.
  localparam logic [31:0] LDUR_MASK   = 32'hBFE0_0000;
  localparam logic [31:0] LDUR_MATCH  = 32'hB840_0000;
  localparam logic [31:0] STUR_MASK   = 32'hBFE0_0000;
  localparam logic [31:0] STUR_MATCH  = 32'hB800_0000;
  // LDP/STP: integer pair class, any addressing mode, either L bit.
  localparam logic [31:0] LDSTP_MASK  = 32'h7C00_0000;
  localparam logic [31:0] LDSTP_MATCH = 32'h2800_0000;
  // HLT #imm16: imm16 in [20:5] is don't-care, low five bits must be zero.
  localparam logic [31:0] HLT_MASK    = 32'hFFE0_001F;
  localparam logic [31:0] HLT_MATCH   = 32'hD440_0000;

  function automatic logic word_match(input logic [31:0] w,
                                      input logic [31:0] mask,
                                      input logic [31:0] match);
    return (w & mask) == match;
  endfunction

endpackage

// File: rtl/dispatch_sequencer_predecode.sv
// Pure combinational pre-decode: classifies an instruction word so the scheduler
// knows which reservation station must have room before it may be released.
module insn_class_predecode
  import dispatch_sequencer_pkg::*;
(
  input  logic [INSNBITS_SIZE-1:0] insnbits_i,
  output insn_class_t              class_o
);

  always_comb begin
    class_o = CLS_ALU;
    if (word_match(insnbits_i, HLT_MASK, HLT_MATCH)) begin
      class_o = CLS_HLT;
    end else if (word_match(insnbits_i, LDUR_MASK, LDUR_MATCH) ||
                 word_match(insnbits_i, STUR_MASK, STUR_MATCH) ||
                 word_match(insnbits_i, LDSTP_MASK, LDSTP_MATCH)) begin
      class_o = CLS_LS;
    end
  end

endmodule

// File: rtl/dispatch_sequencer.sv
// Instruction queue between fetch and dispatch: DEPTH-entry flop FIFO, in-order release
// of one word per cycle gated by ROB/RS/stall, emptied by flush, frozen after HLT.
module dispatch_sequencer
  import dispatch_sequencer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_stall,
  input  logic                     in_flush,
  input  logic [INSNBITS_SIZE-1:0] in_fetch_insnbits,
  input  logic                     in_fetch_done,
  input  logic                     in_rob_free,
  input  logic                     in_rs_alu_free,
  input  logic                     in_rs_ls_free,
  output logic                     out_fetch_stall,
  output logic [INSNBITS_SIZE-1:0] out_dispatch_insnbits,
  output logic                     out_dispatch_done,
  output logic [PTR_W:0]           out_count,
  output logic                     out_halted,
  output logic                     out_overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [INSNBITS_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  seq_state_t               state_q, state_d;
  logic [INSNBITS_SIZE-1:0] insn_q, insn_d;
  logic                     done_q, done_d;
  logic                     overflow_q, overflow_d;

  logic                     full;
  logic                     enq;
  logic                     deq;
  logic                     rs_ok;
  logic [INSNBITS_SIZE-1:0] head_word;
  insn_class_t              head_cls;

  assign head_word = mem_q[rd_ptr_q];

  insn_class_predecode u_predecode (
    .insnbits_i (head_word),
    .class_o    (head_cls)
  );

  assign full  = (count_q == FULL_CNT);
  assign rs_ok = (head_cls == CLS_LS) ? in_rs_ls_free : in_rs_alu_free;
  assign enq   = in_fetch_done && !full && !in_flush;
  // In-order release: a blocked head is never bypassed by a younger word.
  assign deq   = (count_q != '0) && (state_q == SEQ_RUN) && !in_stall && !in_flush &&
                 in_rob_free && rs_ok;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    insn_d     = insn_q;
    done_d     = deq;
    overflow_d = overflow_q | (in_fetch_done & full);

    if (in_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end

    if (deq) begin
      insn_d = head_word;
      if (head_cls == CLS_HLT) state_d = SEQ_HALTED;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= SEQ_RUN;
      insn_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) mem_q[wr_ptr_q] <= in_fetch_insnbits;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      insn_q     <= insn_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_fetch_stall       = full;
  assign out_dispatch_insnbits = insn_q;
  assign out_dispatch_done     = done_q;
  assign out_count             = count_q;
  assign out_halted            = (state_q == SEQ_HALTED);
  assign out_overflow          = overflow_q;

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Bench for dispatch_sequencer: directed scenarios plus random traffic, each checked
// against a queue-based model of the instruction buffer.
module tb_dispatch_sequencer;

  localparam int DEPTH = 4;
  localparam logic [1:0] C_ALU = 2'd0;
  localparam logic [1:0] C_LS  = 2'd1;
  localparam logic [1:0] C_HLT = 2'd2;

  logic        in_clk;
  logic        in_rst_n;
  logic        in_stall;
  logic        in_flush;
  logic [31:0] in_fetch_insnbits;
  logic        in_fetch_done;
  logic        in_rob_free;
  logic        in_rs_alu_free;
  logic        in_rs_ls_free;
  logic        out_fetch_stall;
  logic [31:0] out_dispatch_insnbits;
  logic        out_dispatch_done;
  logic [2:0]  out_count;
  logic        out_halted;
  logic        out_overflow;

  dispatch_sequencer #(.DEPTH(DEPTH)) dut (
    .in_clk                (in_clk),
    .in_rst_n              (in_rst_n),
    .in_stall              (in_stall),
    .in_flush              (in_flush),
    .in_fetch_insnbits     (in_fetch_insnbits),
    .in_fetch_done         (in_fetch_done),
    .in_rob_free           (in_rob_free),
    .in_rs_alu_free        (in_rs_alu_free),
    .in_rs_ls_free         (in_rs_ls_free),
    .out_fetch_stall       (out_fetch_stall),
    .out_dispatch_insnbits (out_dispatch_insnbits),
    .out_dispatch_done     (out_dispatch_done),
    .out_count             (out_count),
    .out_halted            (out_halted),
    .out_overflow          (out_overflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- model state ----------------
  // Each entry is {class, word}; the class is known from how the bench built the word.
  logic [33:0] exp_q[$];
  logic [1:0]  fetch_cls;
  logic [31:0] m_insn;
  bit          m_done, m_halted, m_overflow;
  int          n_vec, n_err;

  function automatic logic [6:0] obs_st();
    return {out_count, out_fetch_stall, out_dispatch_done, out_halted, out_overflow};
  endfunction

  function automatic logic [6:0] exp_st();
    return {3'(exp_q.size()), (exp_q.size() == DEPTH), m_done, m_halted, m_overflow};
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_insn = '0;
    m_done = 0;
    m_halted = 0;
    m_overflow = 0;
  endfunction

  function automatic logic [33:0] gen_word(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0: return {C_HLT, 32'hD440_0000 | {11'd0, r[15:0], 5'd0}};
      1: return {C_LS, 32'hF840_0000 | {11'd0, r[20:0]}};
      2: return {C_LS, 32'hF800_0000 | {11'd0, r[20:0]}};
      3: return {C_LS, 32'hB840_0000 | {11'd0, r[20:0]}};
      4: return {C_LS, 32'hA940_0000 | {10'd0, r[21:0]}};
      5: return {C_LS, 32'hA900_0000 | {10'd0, r[21:0]}};
      default: return {C_ALU, 32'h9100_0000 | {10'd0, r[21:0]}};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fetch(input logic [33:0] e);
    in_fetch_done     = 1'b1;
    in_fetch_insnbits = e[31:0];
    fetch_cls         = e[33:32];
  endtask

  task automatic drive_idle();
    in_fetch_done     = 1'b0;
    in_fetch_insnbits = '0;
    fetch_cls         = C_ALU;
  endtask

  // Advance one clock and move the model along with the inputs held across the edge.
  task automatic tick();
    bit full, enq, deq;
    logic [33:0] head;
    head = '0;
    full = (exp_q.size() == DEPTH);
    enq  = in_fetch_done && !full && !in_flush;
    deq  = 0;
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      deq  = !m_halted && !in_stall && !in_flush && in_rob_free &&
             ((head[33:32] == C_LS) ? in_rs_ls_free : in_rs_alu_free);
    end
    if (in_fetch_done && full) m_overflow = 1;
    @(posedge in_clk);
    #1;
    if (in_flush) begin
      exp_q.delete();
      m_done = 0;
    end else begin
      m_done = deq;
      if (deq) begin
        m_insn = head[31:0];
        void'(exp_q.pop_front());
        if (head[33:32] == C_HLT) m_halted = 1;
      end
      if (enq) exp_q.push_back({fetch_cls, in_fetch_insnbits});
    end
  endtask

  task automatic do_reset();
    in_rst_n = 1'b0;
    in_stall = 0; in_flush = 0; in_rob_free = 0; in_rs_alu_free = 0; in_rs_ls_free = 0;
    drive_idle();
    model_clear();
    #3;
    in_rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++;
    if (obs_st() !== 7'd0 || out_dispatch_insnbits !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: got st=%h insn=%h want st=00 insn=00000000",
               obs_st(), out_dispatch_insnbits);
    end
    in_rs_alu_free = 1;
    for (int i = 0; i < 3; i++) begin
      drive_fetch(gen_word(9));
      tick();
    end
    drive_idle();
    in_rob_free = 1;
    tick();
    n_vec++;
    if (obs_st() !== exp_st() || out_dispatch_insnbits !== m_insn) begin
      n_err++;
      $display("FAIL reset_prefill: got st=%h insn=%h want st=%h insn=%h",
               obs_st(), out_dispatch_insnbits, exp_st(), m_insn);
    end
    in_rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_count !== 3'd0 || out_dispatch_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got count=%0d done=%b want count=0 done=0",
               out_count, out_dispatch_done);
    end
    model_clear();
    #2;
    in_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (obs_st() !== exp_st() || out_dispatch_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_dispatch: got st=%h want st=%h", obs_st(), exp_st());
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    in_rs_alu_free = 1;
    for (int i = 0; i < 5; i++) begin
      drive_fetch({C_ALU, 32'h9100_0420 + 32'(i)});
      tick();
      n_vec++;
      if (obs_st() !== exp_st()) begin
        n_err++;
        $display("FAIL fill[%0d]: got st=%h want st=%h", i, obs_st(), exp_st());
      end
    end
    drive_idle();
    n_vec++;
    if (out_count !== 3'd4 || out_fetch_stall !== 1'b1 || out_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL fill_final: got count=%0d stall=%b ovf=%b want count=4 stall=1 ovf=1",
               out_count, out_fetch_stall, out_overflow);
    end
  endtask

  task automatic test_stream();
    int n_disp;
    logic [31:0] sent[$];
    n_disp = 0;
    do_reset();
    in_rob_free = 1; in_rs_alu_free = 1; in_rs_ls_free = 1;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        drive_fetch(gen_word($urandom_range(1, 15)));
        sent.push_back(in_fetch_insnbits);
      end else begin
        drive_idle();
      end
      tick();
      n_vec++;
      if (obs_st() !== exp_st() || out_dispatch_insnbits !== m_insn || out_count > 3'd1) begin
        n_err++;
        $display("FAIL stream[%0d]: got st=%h insn=%h want st=%h insn=%h",
                 i, obs_st(), out_dispatch_insnbits, exp_st(), m_insn);
      end
      if (out_dispatch_done && sent.size() > 0) begin
        n_disp++;
        n_vec++;
        if (out_dispatch_insnbits !== sent[0] || i != n_disp) begin
          n_err++;
          $display("FAIL stream_order[%0d]: got insn=%h at cycle %0d want insn=%h at cycle %0d",
                   n_disp, out_dispatch_insnbits, i, sent[0], n_disp);
        end
        void'(sent.pop_front());
      end
    end
    n_vec++;
    if (n_disp != 8) begin
      n_err++;
      $display("FAIL stream_count: got %0d pulses want 8", n_disp);
    end
  endtask

  task automatic test_class_gating();
    do_reset();
    in_rob_free = 1; in_rs_alu_free = 1; in_rs_ls_free = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive_fetch({C_LS, 32'hF800_0020});
      else if (i == 1) drive_fetch({C_ALU, 32'h9100_0421});
      else drive_idle();
      if (i == 5) in_rs_ls_free = 1;
      tick();
      n_vec++;
      if (obs_st() !== exp_st() || out_dispatch_insnbits !== m_insn) begin
        n_err++;
        $display("FAIL gating[%0d]: got st=%h insn=%h want st=%h insn=%h",
                 i, obs_st(), out_dispatch_insnbits, exp_st(), m_insn);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_rs_alu_free = 1; in_rs_ls_free = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive_fetch(gen_word(9));
      else if (i == 3) begin
        drive_fetch(gen_word(9));
        in_rob_free = 1;
        in_flush = 1;
      end else begin
        drive_idle();
        in_flush = 0;
      end
      tick();
      n_vec++;
      if (obs_st() !== exp_st() || out_dispatch_insnbits !== m_insn) begin
        n_err++;
        $display("FAIL flush[%0d]: got st=%h insn=%h want st=%h insn=%h",
                 i, obs_st(), out_dispatch_insnbits, exp_st(), m_insn);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    in_rs_alu_free = 1; in_rs_ls_free = 1;
    for (int i = 0; i < 9; i++) begin
      in_flush = 0;
      if (i == 0) drive_fetch({C_HLT, 32'hD440_0000});
      else if (i == 1) drive_fetch({C_ALU, 32'h9100_0420});
      else if (i == 6) drive_fetch({C_ALU, 32'h9100_0555});
      else drive_idle();
      if (i == 2) in_rob_free = 1;
      if (i == 8) in_flush = 1;
      tick();
      n_vec++;
      if (obs_st() !== exp_st() || out_dispatch_insnbits !== m_insn) begin
        n_err++;
        $display("FAIL halt[%0d]: got st=%h insn=%h want st=%h insn=%h",
                 i, obs_st(), out_dispatch_insnbits, exp_st(), m_insn);
      end
    end
    in_flush = 0;
    do_reset();
    tick();
    n_vec++;
    if (out_halted !== 1'b0 || obs_st() !== exp_st()) begin
      n_err++;
      $display("FAIL halt_reset: got st=%h want st=%h", obs_st(), exp_st());
    end
  endtask

  task automatic test_random();
    int halted_cycles;
    halted_cycles = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 60) drive_fetch(gen_word($urandom_range(0, 19)));
      else drive_idle();
      in_stall       = ($urandom_range(0, 99) < 15);
      in_flush       = ($urandom_range(0, 99) < 4);
      in_rob_free    = ($urandom_range(0, 99) < 80);
      in_rs_alu_free = ($urandom_range(0, 99) < 80);
      in_rs_ls_free  = ($urandom_range(0, 99) < 70);
      tick();
      n_vec++;
      if (obs_st() !== exp_st() || out_dispatch_insnbits !== m_insn) begin
        n_err++;
        $display("FAIL random[%0d]: got st=%h insn=%h want st=%h insn=%h",
                 i, obs_st(), out_dispatch_insnbits, exp_st(), m_insn);
      end
      if (m_halted) halted_cycles++;
      if (halted_cycles > 8) begin
        halted_cycles = 0;
        do_reset();
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    in_rst_n = 1'b0;
    in_stall = 0; in_flush = 0; in_rob_free = 0; in_rs_alu_free = 0; in_rs_ls_free = 0;
    drive_idle();
    repeat (2) @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;

    test_reset();
    test_fill();
    test_stream();
    test_class_gating();
    test_flush();
    test_halt();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
